// File: rtl/cpu_dbg_pkg.sv
// -----------------------------------------------------------------------------
// cpu_dbg_pkg
// Shared definitions for the CPU load/debug port master.
//   CPU_ADDR_W  : width of the CPU load/debug address bus
//   CPU_DATA_W  : width of the CPU instruction / readback data bus
//   ldr_state_t : loader FSM states
//   ldr_busy()  : true while a session owns the CPU port
// -----------------------------------------------------------------------------
package cpu_dbg_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LOAD    = 4'd1,
        PAD     = 4'd2,
        RUN     = 4'd3,
        RD_ADDR = 4'd4,
        RD_WAIT = 4'd5,
        RD_SEND = 4'd6,
        DONE    = 4'd7,
        TOUT    = 4'd8
    } ldr_state_t;

    function automatic logic ldr_busy(input ldr_state_t s);
        return (s == LOAD) || (s == PAD) || (s == RUN) ||
               (s == RD_ADDR) || (s == RD_WAIT) || (s == RD_SEND);
    endfunction

endpackage

// File: rtl/dbg_timeout_cnt.sv
// -----------------------------------------------------------------------------
// dbg_timeout_cnt
// Run-phase watchdog. Counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TMO_CYC-1. TMO_CYC=0 disables the flag.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous reset, active-low
//   clr_i  in  zero the counter (has priority over en_i)
//   en_i   in  count this cycle
//   tc_o   out terminal count reached this cycle (qualified by en_i)
// -----------------------------------------------------------------------------
module dbg_timeout_cnt #(
    parameter int TMO_CYC = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CW-1:0] TC_VAL = (TMO_CYC > 0) ? CW'(TMO_CYC - 1) : '0;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (TMO_CYC != 0) && en_i && !clr_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/cpu_prog_loader.sv
// -----------------------------------------------------------------------------
// cpu_prog_loader
// Host-side master for the CPU load/debug port. Streams program bytes from a
// valid/ready source into CPU instruction memory (one byte per address, high
// byte of each 16-bit instruction first), pads odd-length images with 0x00,
// waits for the CPU to report completion, then reads back NUM_REG registers and
// the data-memory window DM[DM_ST..DM_ED-1] and emits them as a byte stream.
// Ports:
//   clk, rst               clock; synchronous active-low reset
//   i_start                session start pulse (honoured in IDLE/DONE/TOUT)
//   s_valid/s_data/s_last  program byte stream in; s_ready accepts
//   o_isReg/o_cpu_addr     CPU load/debug select and address
//   o_inst                 CPU instruction-memory write data
//   i_cpu_data, i_is_done  CPU readback data and run-complete flag
//   m_valid/m_data/m_ready readback byte stream out
//   o_busy                 session in progress
//   o_done/o_timeout/o_ovf sticky status until next i_start or reset
// -----------------------------------------------------------------------------
module cpu_prog_loader
    import cpu_dbg_pkg::*;
#(
    parameter int NUM_REG = 8,
    parameter int DM_ST   = 0,
    parameter int DM_ED   = 10,
    parameter int RD_LAT  = 1,
    parameter int TMO_CYC = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  o_isReg,
    output logic [CPU_ADDR_W-1:0] o_cpu_addr,
    output logic [CPU_DATA_W-1:0] o_inst,
    input  logic [CPU_DATA_W-1:0] i_cpu_data,
    input  logic                  i_is_done,
    output logic                  m_valid,
    output logic [7:0]            m_data,
    input  logic                  m_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic                  o_ovf
);

    localparam int NITEMS = NUM_REG + DM_ED - DM_ST;
    localparam int IDXW   = (NITEMS > 1) ? $clog2(NITEMS) : 1;
    localparam int LATW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NITEMS - 1);
    localparam logic [LATW-1:0] LAT_END  = LATW'(RD_LAT - 1);

    // Parameter sanity: the DM window must be non-empty and fit the 8-bit
    // address space without wrapping, and readback needs at least one cycle
    // of latency to land in RD_WAIT.
    if ((DM_ED <= DM_ST) || (DM_ED > 256) || (DM_ST < 0)) begin : g_bad_dm_window
        $error("cpu_prog_loader: DM window [DM_ST, DM_ED) is empty or exceeds 8-bit address space");
    end
    if (RD_LAT < 1) begin : g_bad_rd_lat
        $error("cpu_prog_loader: RD_LAT must be at least 1");
    end
    if (NUM_REG < 0) begin : g_bad_num_reg
        $error("cpu_prog_loader: NUM_REG must not be negative");
    end

    // Readback item k: registers first, then the DM window.
    function automatic logic item_is_reg(input logic [IDXW-1:0] k);
        return int'(k) < NUM_REG;
    endfunction

    function automatic logic [CPU_ADDR_W-1:0] item_addr(input logic [IDXW-1:0] k);
        int a;
        if (int'(k) < NUM_REG) begin
            a = int'(k);
        end else begin
            a = DM_ST + int'(k) - NUM_REG;
        end
        return CPU_ADDR_W'(a);
    endfunction

    ldr_state_t            state_q, state_d;
    logic [8:0]            cnt_q, cnt_d;     // bytes written so far; 256 must fit
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [IDXW-1:0]       idx_inc;
    logic [LATW-1:0]       lat_q, lat_d;
    logic                  isreg_q, isreg_d;
    logic [CPU_ADDR_W-1:0] addr_q, addr_d;
    logic [CPU_DATA_W-1:0] inst_q, inst_d;
    logic [7:0]            mdata_q, mdata_d;
    logic                  done_q, done_d;
    logic                  tout_q, tout_d;
    logic                  ovf_q, ovf_d;
    logic                  tmo_tc;

    assign idx_inc = idx_q + 1'b1;

    dbg_timeout_cnt #(
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != RUN),
        .en_i  (state_q == RUN),
        .tc_o  (tmo_tc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        isreg_d = isreg_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        mdata_d = mdata_q;
        done_d  = done_q;
        tout_d  = tout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE, TOUT: begin
                if (i_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    tout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    isreg_d = 1'b0;
                    addr_d  = '0;
                    inst_d  = '0;
                end
            end

            LOAD: begin
                // s_ready is high for the whole state, so s_valid alone
                // means a byte is taken this cycle.
                if (s_valid) begin
                    inst_d = s_data;
                    addr_d = cnt_q[7:0];
                    cnt_d  = cnt_q + 9'd1;
                    if (s_last || (cnt_q == 9'd255)) begin
                        if (!s_last) begin
                            ovf_d = 1'b1;
                        end
                        // cnt_q is the count before this byte: an even
                        // cnt_q leaves an odd image that needs a pad byte.
                        state_d = cnt_q[0] ? RUN : PAD;
                    end
                end
            end

            PAD: begin
                inst_d  = '0;
                addr_d  = cnt_q[7:0];
                cnt_d   = cnt_q + 9'd1;
                state_d = RUN;
            end

            RUN: begin
                inst_d = '0;
                // Completion beats the watchdog when both land together.
                if (i_is_done) begin
                    state_d = RD_ADDR;
                    idx_d   = '0;
                    isreg_d = item_is_reg('0);
                    addr_d  = item_addr('0);
                end else if (tmo_tc) begin
                    state_d = TOUT;
                    tout_d  = 1'b1;
                end
            end

            RD_ADDR: begin
                state_d = RD_WAIT;
                lat_d   = '0;
            end

            RD_WAIT: begin
                if (lat_q == LAT_END) begin
                    mdata_d = i_cpu_data;
                    state_d = RD_SEND;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            RD_SEND: begin
                if (m_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        isreg_d = 1'b0;
                        addr_d  = '0;
                    end else begin
                        state_d = RD_ADDR;
                        idx_d   = idx_inc;
                        isreg_d = item_is_reg(idx_inc);
                        addr_d  = item_addr(idx_inc);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lat_q   <= '0;
            isreg_q <= 1'b0;
            addr_q  <= '0;
            inst_q  <= '0;
            mdata_q <= '0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
            isreg_q <= isreg_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            mdata_q <= mdata_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s_ready    = (state_q == LOAD);
    assign m_valid    = (state_q == RD_SEND);
    assign o_busy     = ldr_busy(state_q);
    assign o_isReg    = isreg_q;
    assign o_cpu_addr = addr_q;
    assign o_inst     = inst_q;
    assign m_data     = mdata_q;
    assign o_done     = done_q;
    assign o_timeout  = tout_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_cpu_prog_loader
// Scoreboard bench for cpu_prog_loader. Stimulus pushes expected CPU writes and
// expected readback bytes into queues; negedge monitors pop and compare.
// A second instance with a short watchdog covers the timeout path.
// -----------------------------------------------------------------------------
module tb_cpu_prog_loader;

    localparam int NUM_REG = 8;
    localparam int DM_ST   = 0;
    localparam int DM_ED   = 10;
    localparam int RD_LAT  = 1;
    localparam int NITEMS  = NUM_REG + DM_ED - DM_ST;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic       rst, start, s_valid, s_last, s_ready, isreg, is_done;
    logic       m_valid, busy, done, tout, ovf;
    logic       m_ready = 1'b1;
    logic [7:0] s_data, addr, inst, cpu_data, m_data;

    // Timeout instance
    logic       t_start, t_s_valid, t_s_last, t_s_ready, t_isreg, t_is_done;
    logic       t_m_valid, t_m_ready, t_busy, t_done, t_tout, t_ovf;
    logic [7:0] t_s_data, t_addr, t_inst, t_cpu_data, t_m_data;

    cpu_prog_loader #(
        .NUM_REG (NUM_REG), .DM_ST (DM_ST), .DM_ED (DM_ED),
        .RD_LAT (RD_LAT), .TMO_CYC (65535)
    ) u_dut (
        .clk (clk), .rst (rst), .i_start (start),
        .s_valid (s_valid), .s_data (s_data), .s_last (s_last), .s_ready (s_ready),
        .o_isReg (isreg), .o_cpu_addr (addr), .o_inst (inst),
        .i_cpu_data (cpu_data), .i_is_done (is_done),
        .m_valid (m_valid), .m_data (m_data), .m_ready (m_ready),
        .o_busy (busy), .o_done (done), .o_timeout (tout), .o_ovf (ovf)
    );

    cpu_prog_loader #(
        .NUM_REG (NUM_REG), .DM_ST (DM_ST), .DM_ED (DM_ED),
        .RD_LAT (RD_LAT), .TMO_CYC (16)
    ) u_tmo_dut (
        .clk (clk), .rst (rst), .i_start (t_start),
        .s_valid (t_s_valid), .s_data (t_s_data), .s_last (t_s_last), .s_ready (t_s_ready),
        .o_isReg (t_isreg), .o_cpu_addr (t_addr), .o_inst (t_inst),
        .i_cpu_data (t_cpu_data), .i_is_done (t_is_done),
        .m_valid (t_m_valid), .m_data (t_m_data), .m_ready (t_m_ready),
        .o_busy (t_busy), .o_done (t_done), .o_timeout (t_tout), .o_ovf (t_ovf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // CPU model: one-cycle registered read; r_i = i+1, DM[j] = 0x80+j.
    always @(posedge clk) begin
        cpu_data <= isreg ? (addr + 8'd1) : (8'h80 + addr);
    end

    // Scoreboards
    logic [15:0] exp_w[$];
    logic [7:0]  exp_m[$];
    logic [15:0] wexp;
    logic [7:0]  mexp;
    logic        acc_prev = 1'b0;
    int          acc_cnt  = 0;

    // CPU write monitor: the cycle after an accepted byte shows (addr, inst).
    always @(negedge clk) begin
        if (acc_prev) begin
            if (exp_w.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL load_wr_extra: got %02h/%02h expected no write", addr, inst);
            end else begin
                wexp = exp_w.pop_front();
                check("load_wr", {16'h0, addr, inst}, {16'h0, wexp});
            end
        end
        acc_prev = s_valid && s_ready;
        if (s_valid && s_ready) acc_cnt++;
    end

    // Readback stream monitor with stall-stability checks.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d, hold_a;
    logic       hold_r;
    always @(negedge clk) begin
        if (m_valid && hold_v) begin
            check("stall_data", {24'h0, m_data}, {24'h0, hold_d});
            check("stall_addr", {23'h0, isreg, addr}, {23'h0, hold_r, hold_a});
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        hold_a = addr;
        hold_r = isreg;
        if (m_valid && m_ready) begin
            if (exp_m.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m_extra: got 0x%02h expected no byte", m_data);
            end else begin
                mexp = exp_m.pop_front();
                check("m_data", {24'h0, m_data}, {24'h0, mexp});
            end
        end
    end

    logic t_mv_seen = 1'b0;
    always @(negedge clk) begin
        if (t_m_valid) t_mv_seen = 1'b1;
    end

    // m_ready driver: 0 = always ready, 1 = random, 2 = never ready
    logic [1:0] rdy_mode = 2'd0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            2'd1:    m_ready = 1'($urandom_range(0, 1));
            2'd2:    m_ready = 1'b0;
            default: m_ready = 1'b1;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic push_readback();
        for (int i = 0; i < NUM_REG; i++) exp_m.push_back(8'(i + 1));
        for (int j = DM_ST; j < DM_ED; j++) exp_m.push_back(8'(8'h80 + j));
    endtask

    task automatic wait_done(input string name, input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s: o_done not seen within %0d cycles", name, limit);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, {31'h0, s_ready}, 0);
        check({tag, "_busy"},    {31'h0, busy},    0);
        check({tag, "_done"},    {31'h0, done},    0);
        check({tag, "_tout"},    {31'h0, tout},    0);
        check({tag, "_ovf"},     {31'h0, ovf},     0);
        check({tag, "_m_valid"}, {31'h0, m_valid}, 0);
        check({tag, "_isreg"},   {31'h0, isreg},   0);
        check({tag, "_addr"},    {24'h0, addr},    0);
        check({tag, "_inst"},    {24'h0, inst},    0);
        check({tag, "_m_data"},  {24'h0, m_data},  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    int cyc;
    int acc0;
    logic [7:0] pat[4];

    initial begin
        rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
        is_done = 1'b0;
        t_start = 1'b0; t_s_valid = 1'b0; t_s_last = 1'b0; t_s_data = 8'h00;
        t_is_done = 1'b0; t_m_ready = 1'b1; t_cpu_data = 8'h00;

        // Reset state
        repeat (3) tick();
        check_all_zero("rst");
        rst = 1'b1;
        tick();

        // T1: four-byte even load, no stalls
        pulse_start();
        check("t1_ready", {31'h0, s_ready}, 1);
        check("t1_busy",  {31'h0, busy},    1);
        pat[0] = 8'hA1; pat[1] = 8'hB2; pat[2] = 8'hC3; pat[3] = 8'hD4;
        for (int i = 0; i < 4; i++) exp_w.push_back({8'(i), pat[i]});
        for (int i = 0; i < 4; i++) send(pat[i], i == 3);
        check("t1_run_ready", {31'h0, s_ready}, 0);
        check("t1_run_busy",  {31'h0, busy},    1);
        tick();
        check("t1_writes_left", exp_w.size(), 0);
        check("t1_run_inst", {24'h0, inst}, 8'h00);
        check("t1_run_addr", {24'h0, addr}, 8'h03);

        // i_start while busy is ignored
        pulse_start();
        check("busy_start_ready", {31'h0, s_ready}, 0);
        check("busy_start_busy",  {31'h0, busy},    1);

        // T3: readback with random m_ready stalls
        repeat (20) tick();
        push_readback();
        rdy_mode = 2'd1;
        is_done  = 1'b1;
        wait_done("t3_done", 2000, cyc);
        is_done = 1'b0;
        check("t3_bytes_left", exp_m.size(), 0);
        check("t3_done",  {31'h0, done},  1);
        check("t3_busy",  {31'h0, busy},  0);
        check("t3_isreg", {31'h0, isreg}, 0);
        check("t3_addr",  {24'h0, addr},  0);
        tick();
        rdy_mode = 2'd0;

        // T2: odd load gets a pad write, then full-rate readback
        pulse_start();
        check("t2_done_cleared", {31'h0, done}, 0);
        exp_w.push_back(16'h0011);
        exp_w.push_back(16'h0122);
        exp_w.push_back(16'h0233);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        tick();
        check("t2_pad_addr", {24'h0, addr}, 8'h03);
        check("t2_pad_inst", {24'h0, inst}, 8'h00);
        check("t2_ovf",      {31'h0, ovf},  0);
        check("t2_ready",    {31'h0, s_ready}, 0);
        check("t2_writes_left", exp_w.size(), 0);
        push_readback();
        is_done = 1'b1;
        wait_done("t2_rb_done", 500, cyc);
        is_done = 1'b0;
        // one RUN cycle, then NITEMS items of 2+RD_LAT cycles, seen one negedge later
        check("t2_rb_cycles", cyc, 2 + NITEMS * (2 + RD_LAT));
        check("t2_bytes_left", exp_m.size(), 0);
        tick();

        // T4: watchdog on the TMO_CYC=16 instance
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        t_s_valid = 1'b1; t_s_data = 8'hAA; t_s_last = 1'b0;
        tick();
        t_s_data = 8'hBB; t_s_last = 1'b1;
        tick();
        t_s_valid = 1'b0; t_s_last = 1'b0;
        cyc = 0;
        while (!t_tout && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        // 16 RUN cycles, flag visible on the following negedge
        check("t4_tout_cycles", cyc, 17);
        check("t4_tout",   {31'h0, t_tout},    1);
        check("t4_busy",   {31'h0, t_busy},    0);
        check("t4_no_mv",  {31'h0, t_mv_seen}, 0);
        tick();
        t_start = 1'b1;
        tick();
        t_start = 1'b0;
        check("t4_tout_cleared", {31'h0, t_tout},    0);
        check("t4_restart_ready", {31'h0, t_s_ready}, 1);
        check("t4_restart_state",
              {24'h0, t_isreg, t_done, t_ovf, t_busy, 4'h0},
              {24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0});
        check("t4_restart_bus", {16'h0, t_addr, t_inst | t_m_data}, 32'h0);

        // T5: 300 bytes without s_last -> overflow after 256
        pulse_start();
        for (int i = 0; i < 256; i++) exp_w.push_back({8'(i), 8'(i)});
        acc0 = acc_cnt;
        for (int i = 0; i < 300; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            s_last  = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        check("t5_accepted", acc_cnt - acc0, 256);
        check("t5_writes_left", exp_w.size(), 0);
        check("t5_ovf",   {31'h0, ovf},     1);
        check("t5_ready", {31'h0, s_ready}, 0);
        check("t5_busy",  {31'h0, busy},    1);
        check("t5_run_addr", {24'h0, addr}, 8'hFF);
        check("t5_run_inst", {24'h0, inst}, 8'h00);

        // T6: reset while stalled in RD_SEND, then a clean restart
        rdy_mode = 2'd2;
        is_done  = 1'b1;
        cyc = 0;
        while (!m_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_reached_send", {31'h0, m_valid}, 1);
        tick();
        is_done = 1'b0;
        rst     = 1'b0;
        tick();
        check_all_zero("t6");
        rst      = 1'b1;
        rdy_mode = 2'd0;
        pulse_start();
        check("t6_restart_ready", {31'h0, s_ready}, 1);
        exp_w.push_back(16'h005A);
        exp_w.push_back(16'h01C3);
        send(8'h5A, 1'b0);
        send(8'hC3, 1'b1);
        push_readback();
        is_done = 1'b1;
        wait_done("t6_rb_done", 500, cyc);
        is_done = 1'b0;
        check("t6_bytes_left",  exp_m.size(), 0);
        check("t6_writes_left", exp_w.size(), 0);
        check("t6_done", {31'h0, done}, 1);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
